orb_m16_rx: RTL and testbench

//  Receive end of the M16 orbit telemetry link: recovers bits from the serial orbit line,

---
 rtl/orb_m16_pkg.sv | 14 +
 rtl/orb_bit_sampler.sv | 45 ++++
 rtl/orb_m16_rx.sv | 114 +++++++++++
 tb/tb_orb_m16_rx.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/orb_m16_pkg.sv
// Shared widths, default frame marker and receiver state encoding for the
// M16 orbit telemetry receive path.
package orb_m16_pkg;

    localparam int ORB_WORD_W = 12;
    localparam int ORB_ADDR_W = 11;
    localparam logic [ORB_WORD_W-1:0] ORB_SYNC_WORD = 12'hF21;

    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } orbState_t;

endpackage

// File: rtl/orb_bit_sampler.sv
// Brings the asynchronous orbit line into the clk domain and recovers NRZ bits
// by sampling mid-bit with a phase counter that re-centres on every line edge.
module orb_bit_sampler #(
    parameter int BIT_DIV = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic orbLine,
    output logic bitVal,
    output logic bitStb
);

    localparam int PH_W = $clog2(BIT_DIV);
    localparam logic [PH_W-1:0] PH_LAST   = PH_W'(BIT_DIV - 1);
    localparam logic [PH_W-1:0] PH_SAMPLE = PH_W'(BIT_DIV / 2 - 1);

    logic [2:0]      syncReg;
    logic [PH_W-1:0] phase;
    logic            lineEdge;

    assign lineEdge = syncReg[1] ^ syncReg[2];

    // An edge landing on the sample phase restarts the bit and suppresses the sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            syncReg <= '0;
            phase   <= '0;
            bitVal  <= 1'b0;
            bitStb  <= 1'b0;
        end else begin
            syncReg <= {syncReg[1:0], orbLine};
            bitStb  <= 1'b0;
            if (lineEdge) begin
                phase <= '0;
            end else begin
                if (phase == PH_SAMPLE) begin
                    bitStb <= 1'b1;
                    bitVal <= syncReg[1];
                end
                phase <= (phase == PH_LAST) ? '0 : phase + 1'b1;
            end
        end
    end

endmodule

// File: rtl/orb_m16_rx.sv
// M16 orbit link receiver: hunts for the frame marker, then deserialises
// 12-bit words and writes them with their frame index to the frame RAM.
module orb_m16_rx
    import orb_m16_pkg::*;
#(
    parameter int                     BIT_DIV     = 32,
    parameter int                     FRAME_WORDS = 2048,
    parameter logic [ORB_WORD_W-1:0]  SYNC_WORD   = ORB_SYNC_WORD,
    parameter int                     MISS_MAX    = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  iOrb,
    output logic [ORB_WORD_W-1:0] oWord,
    output logic [ORB_ADDR_W-1:0] oAddr,
    output logic                  oWE,
    output logic                  oFrameStart,
    output logic                  oLocked,
    output logic                  oSyncLost
);

    localparam int MISS_W = $clog2(MISS_MAX + 1);
    localparam logic [MISS_W-1:0]     MISS_LAST = MISS_W'(MISS_MAX - 1);
    localparam logic [ORB_ADDR_W-1:0] IDX_LAST  = ORB_ADDR_W'(FRAME_WORDS - 1);

    logic                  bitVal;
    logic                  bitStb;
    orbState_t             state;
    logic [ORB_WORD_W-1:0] shiftReg;
    logic [ORB_WORD_W-1:0] srNext;
    logic [3:0]            bitCnt;
    logic [ORB_ADDR_W-1:0] wordIdx;
    logic [MISS_W-1:0]     missCnt;

    orb_bit_sampler #(.BIT_DIV(BIT_DIV)) bitSampler (
        .clk     (clk),
        .rst     (rst),
        .orbLine (iOrb),
        .bitVal  (bitVal),
        .bitStb  (bitStb)
    );

    assign srNext = {shiftReg[ORB_WORD_W-2:0], bitVal};

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= HUNT;
            shiftReg    <= '0;
            bitCnt      <= '0;
            wordIdx     <= '0;
            missCnt     <= '0;
            oWord       <= '0;
            oAddr       <= '0;
            oWE         <= 1'b0;
            oFrameStart <= 1'b0;
            oLocked     <= 1'b0;
            oSyncLost   <= 1'b0;
        end else begin
            oWE         <= 1'b0;
            oFrameStart <= 1'b0;
            oSyncLost   <= 1'b0;
            if (bitStb) begin
                shiftReg <= srNext;
                case (state)
                    HUNT: begin
                        if (srNext == SYNC_WORD) begin
                            state       <= LOCK;
                            oLocked     <= 1'b1;
                            oWord       <= SYNC_WORD;
                            oAddr       <= '0;
                            oWE         <= 1'b1;
                            oFrameStart <= 1'b1;
                            bitCnt      <= '0;
                            wordIdx     <= ORB_ADDR_W'(1);
                            missCnt     <= '0;
                        end
                    end
                    LOCK: begin
                        if (bitCnt == 4'd11) begin
                            bitCnt  <= '0;
                            wordIdx <= (wordIdx == IDX_LAST) ? '0 : wordIdx + 1'b1;
                            // Word 0 carries the marker; a run of bad markers drops lock without writing.
                            if (wordIdx != '0) begin
                                oWord <= srNext;
                                oAddr <= wordIdx;
                                oWE   <= 1'b1;
                            end else if (srNext == SYNC_WORD) begin
                                missCnt     <= '0;
                                oWord       <= srNext;
                                oAddr       <= wordIdx;
                                oWE         <= 1'b1;
                                oFrameStart <= 1'b1;
                            end else if (missCnt == MISS_LAST) begin
                                state     <= HUNT;
                                oLocked   <= 1'b0;
                                oSyncLost <= 1'b1;
                                missCnt   <= '0;
                            end else begin
                                missCnt <= missCnt + 1'b1;
                                oWord   <= srNext;
                                oAddr   <= wordIdx;
                                oWE     <= 1'b1;
                            end
                        end else begin
                            bitCnt <= bitCnt + 1'b1;
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_orb_m16_rx.sv
// Directed bench for orb_m16_rx: drives serial frames, logs every RAM write
// and compares the log against hand-built expected write sequences.
`timescale 1ns/1ps
module tb_orb_m16_rx;
    import orb_m16_pkg::*;

    localparam int BIT_DIV     = 32;
    localparam int FRAME_WORDS = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        iOrb = 1'b0;
    logic [11:0] oWord;
    logic [10:0] oAddr;
    logic        oWE;
    logic        oFrameStart;
    logic        oLocked;
    logic        oSyncLost;

    int          compared = 0;
    int          mismatched = 0;
    logic [23:0] wrLog[$];
    logic [23:0] expLog[$];
    int          lostCount = 0;
    int          strayFs = 0;
    logic        prevLost = 1'b0;
    logic        lockedAfterLost = 1'b1;

    always #5 clk = ~clk;

    orb_m16_rx #(
        .BIT_DIV     (BIT_DIV),
        .FRAME_WORDS (FRAME_WORDS),
        .SYNC_WORD   (12'hF21),
        .MISS_MAX    (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .iOrb        (iOrb),
        .oWord       (oWord),
        .oAddr       (oAddr),
        .oWE         (oWE),
        .oFrameStart (oFrameStart),
        .oLocked     (oLocked),
        .oSyncLost   (oSyncLost)
    );

    // Write/event monitor, sampled on the falling edge between DUT updates.
    always @(negedge clk) begin
        if (oWE) wrLog.push_back({oFrameStart, oAddr, oWord});
        if (oFrameStart && !oWE) strayFs++;
        if (prevLost) lockedAfterLost = oLocked;
        if (oSyncLost) lostCount++;
        prevLost = oSyncLost;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic logic [11:0] patWord(input int i);
        return 12'hA5A ^ 12'(i);
    endfunction

    task automatic sendBit(input logic b, input int per);
        iOrb = b;
        repeat (per) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [11:0] w, input int per);
        for (int i = 11; i >= 0; i--) sendBit(w[i], per);
    endtask

    task automatic sendPreamble(input int per);
        for (int i = 0; i < 10; i++) sendBit(logic'(i % 2 == 0), per);
    endtask

    task automatic sendFrame(input logic [11:0] w0, input bit patData, input int per);
        applyStimulus(w0, per);
        for (int i = 1; i < FRAME_WORDS; i++)
            applyStimulus(patData ? patWord(i) : 12'(i), per);
    endtask

    task automatic expWrite(input bit fs, input int addr, input logic [11:0] w);
        expLog.push_back({fs, 11'(addr), w});
    endtask

    task automatic expFrame(input bit w0Written, input bit fs, input logic [11:0] w0,
                            input bit dataWritten, input bit patData);
        if (w0Written) expWrite(fs, 0, w0);
        if (dataWritten)
            for (int i = 1; i < FRAME_WORDS; i++)
                expWrite(1'b0, i, patData ? patWord(i) : 12'(i));
    endtask

    task automatic compareLog(input string tag);
        int n;
        n = (wrLog.size() < expLog.size()) ? wrLog.size() : expLog.size();
        checkOutput({tag, " write count"}, 32'(wrLog.size()), 32'(expLog.size()));
        for (int i = 0; i < n; i++)
            checkOutput($sformatf("%s write %0d {fs,addr,word}", tag, i), 32'(wrLog[i]), 32'(expLog[i]));
        checkOutput({tag, " stray frameStart"}, 32'(strayFs), 32'd0);
    endtask

    task automatic startTest();
        iOrb = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wrLog.delete();
        expLog.delete();
        lostCount = 0;
        strayFs = 0;
        lockedAfterLost = 1'b1;
    endtask

    initial begin
        logic [16:0] noise;
        int          periods[2];

        // Reset mid-stream aborts the word and the receiver relocks from scratch.
        startTest();
        checkOutput("t1 outputs after reset", {oWord, oAddr, oWE, oFrameStart, oLocked, oSyncLost}, 32'd0);
        sendPreamble(BIT_DIV);
        applyStimulus(12'hF21, BIT_DIV);
        applyStimulus(12'd1, BIT_DIV);
        for (int i = 0; i < 6; i++) sendBit(1'b0, BIT_DIV);
        checkOutput("t1 writes before reset", 32'(wrLog.size()), 32'd2);
        checkOutput("t1 locked before reset", 32'(oLocked), 32'd1);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("t1 outputs in reset", {oWord, oAddr, oWE, oFrameStart, oLocked, oSyncLost}, 32'd0);
        rst = 1'b0;
        wrLog.delete();
        expLog.delete();
        @(negedge clk);
        checkOutput("t1 unlocked after reset", 32'(oLocked), 32'd0);
        for (int i = 0; i < 6; i++) sendBit(logic'(i == 4), BIT_DIV);
        applyStimulus(12'd3, BIT_DIV);
        sendFrame(12'hF21, 1'b0, BIT_DIV);
        expFrame(1'b1, 1'b1, 12'hF21, 1'b1, 1'b0);
        compareLog("t1");

        // Two clean frames with word value == index.
        startTest();
        sendPreamble(BIT_DIV);
        sendFrame(12'hF21, 1'b0, BIT_DIV);
        sendFrame(12'hF21, 1'b0, BIT_DIV);
        expFrame(1'b1, 1'b1, 12'hF21, 1'b1, 1'b0);
        expFrame(1'b1, 1'b1, 12'hF21, 1'b1, 1'b0);
        compareLog("t2");
        checkOutput("t2 locked", 32'(oLocked), 32'd1);

        // Isolated bad markers: written without frameStart, miss count cleared by good ones.
        startTest();
        sendPreamble(BIT_DIV);
        sendFrame(12'hF21, 1'b0, BIT_DIV);
        sendFrame(12'hF21, 1'b0, BIT_DIV);
        sendFrame(12'h000, 1'b0, BIT_DIV);
        sendFrame(12'hF21, 1'b0, BIT_DIV);
        sendFrame(12'h000, 1'b0, BIT_DIV);
        sendFrame(12'h000, 1'b0, BIT_DIV);
        sendFrame(12'hF21, 1'b0, BIT_DIV);
        expFrame(1'b1, 1'b1, 12'hF21, 1'b1, 1'b0);
        expFrame(1'b1, 1'b1, 12'hF21, 1'b1, 1'b0);
        expFrame(1'b1, 1'b0, 12'h000, 1'b1, 1'b0);
        expFrame(1'b1, 1'b1, 12'hF21, 1'b1, 1'b0);
        expFrame(1'b1, 1'b0, 12'h000, 1'b1, 1'b0);
        expFrame(1'b1, 1'b0, 12'h000, 1'b1, 1'b0);
        expFrame(1'b1, 1'b1, 12'hF21, 1'b1, 1'b0);
        compareLog("t3");
        checkOutput("t3 syncLost pulses", 32'(lostCount), 32'd0);
        checkOutput("t3 locked", 32'(oLocked), 32'd1);

        // Three consecutive bad markers lose lock; the next good marker relocks.
        startTest();
        sendPreamble(BIT_DIV);
        sendFrame(12'hF21, 1'b0, BIT_DIV);
        sendFrame(12'h000, 1'b0, BIT_DIV);
        sendFrame(12'h000, 1'b0, BIT_DIV);
        sendFrame(12'h000, 1'b0, BIT_DIV);
        checkOutput("t4 syncLost pulses", 32'(lostCount), 32'd1);
        checkOutput("t4 locked after loss", 32'(lockedAfterLost), 32'd0);
        checkOutput("t4 unlocked during hunt", 32'(oLocked), 32'd0);
        sendFrame(12'hF21, 1'b0, BIT_DIV);
        expFrame(1'b1, 1'b1, 12'hF21, 1'b1, 1'b0);
        expFrame(1'b1, 1'b0, 12'h000, 1'b1, 1'b0);
        expFrame(1'b1, 1'b0, 12'h000, 1'b1, 1'b0);
        expFrame(1'b0, 1'b0, 12'h000, 1'b0, 1'b0);
        expFrame(1'b1, 1'b1, 12'hF21, 1'b1, 1'b0);
        compareLog("t4");
        checkOutput("t4 relocked", 32'(oLocked), 32'd1);

        // Transmitter bit period off by one clock either way.
        periods[0] = BIT_DIV + 1;
        periods[1] = BIT_DIV - 1;
        foreach (periods[p]) begin
            startTest();
            sendPreamble(periods[p]);
            for (int f = 0; f < 4; f++) begin
                sendFrame(12'hF21, 1'b1, periods[p]);
                expFrame(1'b1, 1'b1, 12'hF21, 1'b1, 1'b1);
            end
            compareLog($sformatf("t5 period %0d", periods[p]));
        end

        // Marker embedded in noise off any 12-bit boundary sets the word alignment.
        startTest();
        noise = 17'b0110_1100_1011_0100_1;
        for (int i = 16; i >= 0; i--) sendBit(noise[i], BIT_DIV);
        applyStimulus(12'hF21, BIT_DIV);
        applyStimulus(12'd1, BIT_DIV);
        applyStimulus(12'd2, BIT_DIV);
        expWrite(1'b1, 0, 12'hF21);
        expWrite(1'b0, 1, 12'd1);
        expWrite(1'b0, 2, 12'd2);
        compareLog("t6");
        checkOutput("t6 locked", 32'(oLocked), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
